// File: rtl/serial_parity_rx_pkg.sv
// Shared types for the serial parity link receiver: FSM state encoding and the XOR gate helper.
// The transmitter side uses the same state values.
package serial_parity_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  function automatic logic gxor(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// Running XOR register: loads init on clr, folds d in on en, otherwise holds.
// One-cycle update latency; no backpressure (enables come straight from the receiver FSM).
module serial_parity_rx_parity_acc
  import serial_parity_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic init,
  input  logic en,
  input  logic d,
  output logic acc
);

  logic acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else if (clr) begin
      acc_q <= init;
    end else if (en) begin
      acc_q <= gxor(acc_q, d);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver (start, DATA_W bits LSB first, parity, stop) with parity and framing flags.
// data_valid pulses the cycle after the stop-bit edge; only bit_valid strobes advance the frame, no backpressure.
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              busy_q;

  logic acc;
  logic acc_clr;
  logic acc_en;

  // The accumulator starts at PARITY_ODD so its final value is 1 exactly on a mismatch.
  assign acc_clr = bit_valid && (state_q == ST_IDLE) && !bit_in;
  assign acc_en  = bit_valid && ((state_q == ST_DATA) || (state_q == ST_PARITY));

  serial_parity_rx_parity_acc u_parity_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .init  (PARITY_ODD),
    .en    (acc_en),
    .d     (bit_in),
    .acc   (acc)
  );

  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt_q == CNT_W'(i)) shift_d[i] = bit_in;
    end
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (bit_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (!bit_in) begin
              state_q <= ST_DATA;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (cnt_q == LAST_IDX) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            perr_q  <= gxor(acc, bit_in);
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            data_out_q   <= shift_q;
            parity_err_q <= perr_q;
            frame_err_q  <= ~bit_in;
            data_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: directed frames plus randomized frames scored against a word-level model.
module tb_serial_parity_rx;

  localparam int DATA_W     = 8;
  localparam bit PARITY_ODD = 1'b0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bit_valid = 1'b0;
  logic              bit_in = 1'b1;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic dv_prev = 1'b0;

  serial_parity_rx #(.DATA_W(DATA_W), .PARITY_ODD(PARITY_ODD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counting and width checking happen on the falling edge.
  always @(negedge clk) begin
    if (data_valid) begin
      pulses++;
      check("dv_single_cycle", {31'd0, dv_prev}, 32'd0);
    end
    dv_prev = data_valid;
  end

  // Correct parity bit for a word, from the population count.
  function automatic logic good_parity(input logic [DATA_W-1:0] d);
    return logic'((($countones(d) % 2) != 0) ^ PARITY_ODD);
  endfunction

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    bit_in    = 1'($urandom);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic pbit, input logic sbit,
                            input int maxgap);
    logic exp_perr;
    logic exp_ferr;
    exp_perr = logic'(((($countones(d) + int'(pbit)) % 2) != 0) != PARITY_ODD);
    exp_ferr = (sbit == 1'b0);
    send_bit(1'b0, $urandom_range(maxgap, 0));
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i], $urandom_range(maxgap, 0));
    send_bit(pbit, $urandom_range(maxgap, 0));
    send_bit(sbit, $urandom_range(maxgap, 0));
    exp_pulses++;
    check("data_valid", {31'd0, data_valid}, 32'd1);
    check("data_out",   {24'd0, data_out},   {24'd0, d});
    check("parity_err", {31'd0, parity_err}, {31'd0, exp_perr});
    check("frame_err",  {31'd0, frame_err},  {31'd0, exp_ferr});
    check("busy_after", {31'd0, busy},       32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out",   {24'd0, data_out},   32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err",  {31'd0, frame_err},  32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed frames
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    @(posedge clk); #1;
    check("dv_cleared", {31'd0, data_valid}, 32'd0);
    send_frame(8'h01, 1'b0, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 0);

    // Flags and word hold while idle strobes arrive
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, 0);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end
    check("hold_data_out",  {24'd0, data_out},  32'h3C);
    check("hold_frame_err", {31'd0, frame_err}, 32'd1);

    // Reset in the middle of a frame
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",      {31'd0, busy},       32'd0);
    check("midrst_data_out",  {24'd0, data_out},   32'd0);
    check("midrst_frame_err", {31'd0, frame_err},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h3C, 1'b0, 1'b1, 0);

    // Gapped strobes, then back-to-back frames
    send_frame(8'h5A, good_parity(8'h5A), 1'b1, 3);
    send_frame(8'h12, good_parity(8'h12), 1'b1, 0);
    send_frame(8'h34, good_parity(8'h34), 1'b1, 0);

    // Randomized frames with occasional bad parity/stop and idle strobes between frames
    for (int n = 0; n < 40; n++) begin
      logic [DATA_W-1:0] d;
      logic pb;
      logic sb;
      d  = DATA_W'($urandom);
      pb = ($urandom_range(3, 0) == 0) ? ~good_parity(d) : good_parity(d);
      sb = ($urandom_range(4, 0) != 0);
      repeat ($urandom_range(2, 0)) send_bit(1'b1, $urandom_range(2, 0));
      send_frame(d, pb, sb, $urandom_range(2, 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("pulse_count", pulses, exp_pulses);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
